pico_frame_receiver: RTL and testbench
======================================

# pico_frame_receiver

- Serial-to-parallel receiver for the controller-to-peripheral (PICO) direction of the readout link.
- Deserializes the controller's bit stream on `sclk`: one command byte, then data bytes.
- Write frames produce register-write strobes; read frames produce the address that drives the readout mux select.
- Sits between the chip's serial pads and the configuration register file / readout mux.

## Interface
Parameters:
- NUM_REGS, 59, highest valid register address; address 0 is reserved.
- ADDR_W, 7, width of the register address field in the command byte.

Ports:
- sclk  input  1  serial clock; all logic on posedge; one clock, no other domain.
- rst  input  1  asynchronous, active-high reset.
- frame_valid  input  1  high for the whole transaction; low = idle/abort.
- serial_in  input  1  serial data, LSB first, sampled on posedge sclk when frame_valid=1.
- wr_en  output  1  one-cycle write strobe.
- wr_addr  output  8  write address (zero-extended from ADDR_W).
- wr_data  output  8  write data byte.
- rd_active  output  1  high while a read frame is in progress.
- rd_addr  output  8  read address, drives readout mux select; 0 when not reading.
- addr_err  output  1  sticky: frame touched address 0 or address > NUM_REGS.

## Operation
- Command byte: bits [6:0] = start address; bit 7 = 1 read, 0 write.
- States:
  - IDLE: frame_valid=0.
  - CMD: collecting the command byte.
  - WR: collecting data bytes.
  - RD: streaming out.
- IDLE -> CMD on the first posedge with frame_valid=1; that edge samples bit 0.
- 3-bit bit counter counts 0..7 and wraps. The 8th sampled bit completes a byte.
- CMD completion:
  - Latch the address into cur_addr.
  - Go to RD if bit 7=1, else WR.
  - If the address is 0 or > NUM_REGS, set addr_err.
- WR byte completion:
  - If cur_addr is in 1..NUM_REGS: register wr_data=byte, wr_addr=cur_addr, wr_en=1.
  - Otherwise: no strobe; set addr_err.
  - Then advance cur_addr (see Configuration).
- RD:
  - rd_active=1; rd_addr=cur_addr, or 0 if out of range.
  - serial_in is ignored.
  - Every 8th posedge, cur_addr advances, in lockstep with the readout serializer's byte slots.
- frame_valid=0 on any posedge:
  - Next state IDLE; bit counter and shift register cleared; partial byte discarded.
  - wr_en=0, rd_active=0, rd_addr=0.
- addr_err holds until cleared on the first posedge of the next frame (IDLE -> CMD).
- Address arithmetic is ADDR_W bits: 127 + 1 wraps to 0, which is invalid.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, rd_active=0, rd_addr=0, addr_err=0; state IDLE; counters 0.
- wr_en rises on the posedge that samples bit 7 of a data byte and falls on the next posedge. It is high for exactly one cycle per byte, so there are always ≥7 idle cycles between strobes.
- wr_addr and wr_data change only on strobe edges and hold between strobes.
- rd_addr is valid from the posedge that samples command bit 7. It updates every 8 posedges thereafter.
- A frame that drops in the same cycle a byte would complete is aborted: no strobe, no address advance.
- rst mid-frame immediately forces all outputs to reset values; any strobe in flight is lost.

## Configuration
- `PICO_AUTOINC_EN` defined:
  - cur_addr increments by 1 after each data byte in WR.
  - cur_addr increments by 1 after each 8-cycle slot in RD.
- Undefined:
  - cur_addr is fixed for the whole frame.
  - Repeated WR bytes rewrite the same register; RD repeatedly selects the same register.
  - Wrap/overflow addr_err cases cannot arise.

## Structure
- Shared package (pico_pkg), holding:
  - state enum (IDLE, CMD, WR, RD);
  - NUM_REGS;
  - the reserved address constant 0;
  - the command-bit-7 read flag position.
- One natural sub-module: s2p_shift8, an 8-bit LSB-first shift register with bit counter and byte_done pulse. It is the mirror of the existing p2s serializer and clears on frame drop.

## Test plan
- Write frame, cmd 0x05 then data 0xA5 -> wr_en one cycle with wr_addr=5, wr_data=0xA5; addr_err=0.
- Burst write, cmd 0x3A then 0x11, 0x22 with AUTOINC:
  - AUTOINC defined -> writes (58,0x11), (59,0x22).
  - AUTOINC undefined -> both writes go to 58.
- Write to address 0 or 60 -> no wr_en; addr_err=1; addr_err clears on the next frame's first edge.
- Read frame, cmd 0x81 for 24 cycles after the command -> rd_active=1; rd_addr 1,2,3 at 8-cycle steps (AUTOINC); rd_addr=0 after frame_valid falls.
- frame_valid dropped after 5 data bits, then a new frame cmd 0x02 + 0x7F -> partial byte discarded; single write (2,0x7F).
- rst asserted mid-write -> all outputs 0 asynchronously; the next frame after release decodes correctly.

Source files
------------

// File: rtl/pico_pkg.sv
// Shared types and constants for the PICO frame receiver.
// Optional feature macro: PICO_AUTOINC_EN (address auto-increment).
package pico_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WR,
    RD
  } state_t;

  localparam int NUM_REGS    = 59;
  localparam int ADDR_W      = 7;
  localparam int RSVD_ADDR   = 0;
  localparam int RD_FLAG_BIT = 7;

endpackage

// File: rtl/pico_frame_receiver_if.sv
// Controller-side serial inputs and register-file side outputs.
// master drives the link, slave is the receiver.
interface pico_frame_receiver_if;

  logic       frame_valid;
  logic       serial_in;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_active;
  logic [7:0] rd_addr;
  logic       addr_err;

  modport master (
    output frame_valid,
    output serial_in,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  rd_active,
    input  rd_addr,
    input  addr_err
  );

  modport slave (
    input  frame_valid,
    input  serial_in,
    output wr_en,
    output wr_addr,
    output wr_data,
    output rd_active,
    output rd_addr,
    output addr_err
  );

endinterface

// File: rtl/pico_frame_receiver_s2p_shift8.sv
// LSB-first 8-bit deserializer with wrapping bit counter.
// Mirror of the p2s serializer; clears whenever en drops.
module s2p_shift8 (
  input  logic       sclk,
  input  logic       rst,
  input  logic       en,
  input  logic       din,
  output logic [7:0] data,
  output logic       done
);

  logic [2:0] cnt;
  logic [6:0] sr;

  // the 8th bit is taken straight from din so the byte
  // is usable on the same edge that samples it
  assign data = {din, sr};
  assign done = en && (cnt == 3'd7);

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sr  <= '0;
    end else if (!en) begin
      cnt <= '0;
      sr  <= '0;
    end else begin
      cnt <= cnt + 3'd1;
      sr  <= {din, sr[6:1]};
    end
  end

endmodule

// File: rtl/pico_frame_receiver.sv
// PICO frame receiver: command byte then write data or read slots.
// Define PICO_AUTOINC_EN to auto-increment the address per byte.
module pico_frame_receiver
  import pico_pkg::*;
#(
  parameter int NUM_REGS = pico_pkg::NUM_REGS,
  parameter int ADDR_W   = pico_pkg::ADDR_W
) (
  input  logic                  sclk,
  input  logic                  rst,
  pico_frame_receiver_if.slave  bus
);

  typedef logic [ADDR_W-1:0] addr_t;

  state_t     state;
  addr_t      cur_addr;
  addr_t      nxt_addr;
  addr_t      cmd_addr;
  logic [7:0] rx_byte;
  logic       byte_done;

  logic       wr_en_q;
  logic [7:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic       rd_active_q;
  logic [7:0] rd_addr_q;
  logic       addr_err_q;

  function automatic logic in_range(addr_t a);
    return (a != addr_t'(RSVD_ADDR)) && (int'(a) <= NUM_REGS);
  endfunction

  s2p_shift8 u_s2p (
    .sclk (sclk),
    .rst  (rst),
    .en   (bus.frame_valid),
    .din  (bus.serial_in),
    .data (rx_byte),
    .done (byte_done)
  );

  assign cmd_addr = rx_byte[ADDR_W-1:0];

`ifdef PICO_AUTOINC_EN
  assign nxt_addr = cur_addr + addr_t'(1);
`else
  assign nxt_addr = cur_addr;
`endif

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur_addr    <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_active_q <= 1'b0;
      rd_addr_q   <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (!bus.frame_valid) begin
        state       <= IDLE;
        rd_active_q <= 1'b0;
        rd_addr_q   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state      <= CMD;
            addr_err_q <= 1'b0;
          end
          CMD: begin
            if (byte_done) begin
              cur_addr <= cmd_addr;
              if (!in_range(cmd_addr))
                addr_err_q <= 1'b1;
              if (rx_byte[RD_FLAG_BIT]) begin
                state       <= RD;
                rd_active_q <= 1'b1;
                rd_addr_q   <= in_range(cmd_addr) ? 8'(cmd_addr) : '0;
              end else begin
                state <= WR;
              end
            end
          end
          WR: begin
            if (byte_done) begin
              if (in_range(cur_addr)) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= 8'(cur_addr);
                wr_data_q <= rx_byte;
              end else begin
                addr_err_q <= 1'b1;
              end
              cur_addr <= nxt_addr;
            end
          end
          RD: begin
            // slot boundary of the readout serializer
            if (byte_done) begin
              cur_addr  <= nxt_addr;
              rd_addr_q <= in_range(nxt_addr) ? 8'(nxt_addr) : '0;
              if (!in_range(nxt_addr))
                addr_err_q <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rd_active = rd_active_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_pico_frame_receiver.sv
// Bench for pico_frame_receiver: write-frame table, read slots,
// aborts and async reset, with a write-strobe scoreboard.
module tb_pico_frame_receiver;

  typedef struct {
    logic [7:0] cmd;
    int         nd;
    logic [7:0] d0;
    logic [7:0] d1;
    int         nw;
    logic [7:0] a0;
    logic [7:0] a1;
    logic       err;
  } vec_t;

  logic sclk = 1'b0;
  logic rst;

  pico_frame_receiver_if bus ();

  pico_frame_receiver dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 sclk = ~sclk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb_q[$];
  logic [15:0] sb_e;
  logic        wr_en_prev = 1'b0;
  vec_t        vecs[5];
  logic [7:0]  rb;
  logic [7:0]  rd_exp;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge sclk) begin
    if (bus.wr_en) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe got addr %h data %h want none",
                 bus.wr_addr, bus.wr_data);
      end else begin
        sb_e = sb_q.pop_front();
        chk("wr_addr", bus.wr_addr, sb_e[15:8]);
        chk("wr_data", bus.wr_data, sb_e[7:0]);
      end
      chk("wr_en_width", {7'd0, wr_en_prev}, 8'd0);
    end
    wr_en_prev = bus.wr_en;
  end

  task automatic send_bits(input logic [7:0] b, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.frame_valid = 1'b1;
      bus.serial_in   = b[i];
      @(negedge sclk);
    end
  endtask

  task automatic idle(input int n);
    bus.frame_valid = 1'b0;
    bus.serial_in   = 1'b0;
    repeat (n) @(negedge sclk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"},     {7'd0, bus.wr_en},     8'd0);
    chk({tag, "_wr_addr"},   bus.wr_addr,           8'd0);
    chk({tag, "_wr_data"},   bus.wr_data,           8'd0);
    chk({tag, "_rd_active"}, {7'd0, bus.rd_active}, 8'd0);
    chk({tag, "_rd_addr"},   bus.rd_addr,           8'd0);
    chk({tag, "_addr_err"},  {7'd0, bus.addr_err},  8'd0);
  endtask

  initial begin
    vecs[0] = '{8'h05, 1, 8'hA5, 8'h00, 1, 8'd5,  8'd0,  1'b0};
`ifdef PICO_AUTOINC_EN
    vecs[1] = '{8'h3A, 2, 8'h11, 8'h22, 2, 8'd58, 8'd59, 1'b0};
    vecs[4] = '{8'h3B, 2, 8'h55, 8'h66, 1, 8'd59, 8'd0,  1'b1};
`else
    vecs[1] = '{8'h3A, 2, 8'h11, 8'h22, 2, 8'd58, 8'd58, 1'b0};
    vecs[4] = '{8'h3B, 2, 8'h55, 8'h66, 2, 8'd59, 8'd59, 1'b0};
`endif
    vecs[2] = '{8'h00, 1, 8'h33, 8'h00, 0, 8'd0,  8'd0,  1'b1};
    vecs[3] = '{8'h3C, 1, 8'h44, 8'h00, 0, 8'd0,  8'd0,  1'b1};

    rst             = 1'b1;
    bus.frame_valid = 1'b0;
    bus.serial_in   = 1'b0;
    repeat (2) @(negedge sclk);
    chk_all_zero("reset");
    rst = 1'b0;
    idle(2);

    for (int r = 0; r < 5; r++) begin
      if (vecs[r].nw > 0) sb_q.push_back({vecs[r].a0, vecs[r].d0});
      if (vecs[r].nw > 1) sb_q.push_back({vecs[r].a1, vecs[r].d1});
      send_bits(vecs[r].cmd, 0, 0);
      chk($sformatf("err_clear%0d", r), {7'd0, bus.addr_err}, 8'd0);
      send_bits(vecs[r].cmd, 1, 7);
      send_bits(vecs[r].d0, 0, 7);
      if (vecs[r].nd > 1) send_bits(vecs[r].d1, 0, 7);
      idle(2);
      chk($sformatf("addr_err%0d", r), {7'd0, bus.addr_err},
          {7'd0, vecs[r].err});
      chk($sformatf("sb_drain%0d", r), 8'(sb_q.size()), 8'd0);
    end

    // read frame: address slots every 8 edges after the command
    send_bits(8'h81, 0, 7);
    chk("rd_active", {7'd0, bus.rd_active}, 8'd1);
    chk("rd_addr0", bus.rd_addr, 8'd1);
    rd_exp = 8'd1;
    for (int k = 1; k <= 2; k++) begin
      rb = 8'($urandom);
      send_bits(rb, 0, 3);
      chk($sformatf("rd_hold%0d", k), bus.rd_addr, rd_exp);
      send_bits(rb, 4, 7);
`ifdef PICO_AUTOINC_EN
      rd_exp = rd_exp + 8'd1;
`endif
      chk($sformatf("rd_addr%0d", k), bus.rd_addr, rd_exp);
    end
    send_bits(8'hFF, 0, 2);
    idle(1);
    chk("rd_active_off", {7'd0, bus.rd_active}, 8'd0);
    chk("rd_addr_off", bus.rd_addr, 8'd0);
    chk("rd_err", {7'd0, bus.addr_err}, 8'd0);

    // abort after 5 data bits, then a clean frame
    send_bits(8'h02, 0, 7);
    send_bits(8'hFF, 0, 4);
    idle(1);
    sb_q.push_back({8'h02, 8'h7F});
    send_bits(8'h02, 0, 7);
    send_bits(8'h7F, 0, 7);
    idle(2);
    chk("abort5_drain", 8'(sb_q.size()), 8'd0);

    // drop on the edge that would complete the byte
    send_bits(8'h03, 0, 7);
    send_bits(8'hEE, 0, 6);
    idle(2);
    chk("abort7_wr_addr", bus.wr_addr, 8'h02);
    chk("abort7_wr_data", bus.wr_data, 8'h7F);

    // async reset in the middle of a read frame
    send_bits(8'h81, 0, 7);
    send_bits(8'h00, 0, 2);
    chk("pre_rst_rd", {7'd0, bus.rd_active}, 8'd1);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    bus.frame_valid = 1'b0;
    @(negedge sclk);
    rst = 1'b0;
    idle(2);
    sb_q.push_back({8'h09, 8'hC3});
    send_bits(8'h09, 0, 7);
    send_bits(8'hC3, 0, 7);
    idle(2);
    chk("post_rst_wr_addr", bus.wr_addr, 8'h09);
    chk("post_rst_wr_data", bus.wr_data, 8'hC3);
    chk("final_drain", 8'(sb_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
